// File: rtl/icache_ctrl_pkg.sv
// icache_def: shared types and geometry for the direct-mapped instruction cache.
package icache_def;
  localparam int TAG_W = 8;
  localparam int IDX_W = 6;
  localparam int LINES = 1 << IDX_W;
  localparam int LINE_W = 64;
  localparam int LADDR_W = TAG_W + IDX_W;
  typedef struct packed {
    logic [LADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic rw;
    logic valid;
  } mem_req_type;
  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic ready;
  } mem_data_type;
  typedef enum logic [1:0] {COMPARE, ALLOCATE, FILL} state_t;
endpackage

// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: fetch-side and unified-memory-side signals of the instruction cache.
interface icache_ctrl_if;
  import icache_def::*;
  logic [15:0] pc;
  logic fetch_en;
  logic flush;
  mem_data_type mem_data_res;
  logic [15:0] instr;
  logic hit;
  logic stall;
  mem_req_type mem_req;
  logic [15:0] miss_cnt;
  modport master (output pc, fetch_en, flush, mem_data_res, input instr, hit, stall, mem_req, miss_cnt);
  modport slave (input pc, fetch_en, flush, mem_data_res, output instr, hit, stall, mem_req, miss_cnt);
endinterface

// File: rtl/icache_data_array.sv
// icache_data_array: line storage, one synchronous write port and one asynchronous read port.
module icache_data_array
  import icache_def::*;
(
  input  logic clk,
  input  logic i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [LINE_W-1:0] o_rdata
);
  logic [LINE_W-1:0] r_mem [LINES];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: 64-line direct-mapped instruction cache with zero-cycle hits
// and a blocking single-line refill from unified memory.
module icache_ctrl
  import icache_def::*;
(
  input  logic clk,
  input  logic rst,
  icache_ctrl_if.slave bus
);
  state_t r_state;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [LADDR_W-1:0] r_miss_line;
  logic [LINE_W-1:0] r_line_buf;
  logic [15:0] r_miss_cnt;
  logic [LINE_W-1:0] w_line;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_fill_idx;
  logic w_fill;
  logic w_hit;
  logic w_miss;
  assign w_idx = bus.pc[7:2];
  assign w_fill_idx = r_miss_line[IDX_W-1:0];
  assign w_fill = r_state == FILL;
  assign w_hit = r_state == COMPARE && bus.fetch_en && r_valid[w_idx] && r_tag[w_idx] == bus.pc[15:8];
  assign w_miss = r_state == COMPARE && bus.fetch_en && !w_hit;
  icache_data_array u_data (
    .clk     (clk),
    .i_we    (w_fill),
    .i_waddr (w_fill_idx),
    .i_wdata (r_line_buf),
    .i_raddr (w_idx),
    .o_rdata (w_line)
  );
  always_ff @(posedge clk)
    if (w_fill) r_tag[w_fill_idx] <= r_miss_line[LADDR_W-1:IDX_W];
  // flush has priority so a line written during FILL stays invalid
  always_ff @(posedge clk or posedge rst)
    if (rst) r_valid <= '0;
    else if (bus.flush) r_valid <= '0;
    else if (w_fill) r_valid[w_fill_idx] <= 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= COMPARE;
      r_miss_line <= '0;
      r_line_buf <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        COMPARE: if (w_miss) begin
          r_miss_line <= bus.pc[15:2];
          r_miss_cnt <= r_miss_cnt == 16'hFFFF ? r_miss_cnt : r_miss_cnt + 16'd1;
          r_state <= ALLOCATE;
        end
        ALLOCATE: if (bus.mem_data_res.ready) begin
          r_line_buf <= bus.mem_data_res.data;
          r_state <= FILL;
        end
        default: r_state <= COMPARE;
      endcase
    end
  assign bus.hit = w_hit;
  assign bus.instr = w_hit ? w_line[{bus.pc[1:0], 4'd0} +: 16] : 16'h0000;
  assign bus.stall = !rst && (r_state != COMPARE || w_miss);
  assign bus.miss_cnt = r_miss_cnt;
  assign bus.mem_req.valid = r_state == ALLOCATE;
  assign bus.mem_req.addr = r_miss_line;
  assign bus.mem_req.data = '0;
  assign bus.mem_req.rw = 1'b0;
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed checks of hits, misses, refill timing, flush and reset.
module tb_icache_ctrl;
  import icache_def::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  icache_ctrl_if bus ();
  icache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_miss(input logic [15:0] a, input logic [63:0] d, input int dly, input logic fl);
    bus.pc = a;
    bus.fetch_en = 1'b1;
    #1;
    chk("miss_hit", bus.hit, 1'b0);
    chk("miss_stall", bus.stall, 1'b1);
    tick();
    chk("alloc_valid", bus.mem_req.valid, 1'b1);
    chk("alloc_addr", bus.mem_req.addr, a[15:2]);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("wait_valid", bus.mem_req.valid, 1'b1);
      chk("wait_addr", bus.mem_req.addr, a[15:2]);
      chk("wait_stall", bus.stall, 1'b1);
    end
    bus.mem_data_res.data = d;
    bus.mem_data_res.ready = 1'b1;
    tick();
    bus.mem_data_res.ready = 1'b0;
    bus.flush = fl;
    chk("fill_stall", bus.stall, 1'b1);
    chk("fill_valid", bus.mem_req.valid, 1'b0);
    tick();
    bus.flush = 1'b0;
    bus.fetch_en = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [15:0] a, input logic h, input logic [15:0] ins);
    bus.pc = a;
    bus.fetch_en = 1'b1;
    #1;
    chk({tag, "_hit"}, bus.hit, h);
    chk({tag, "_instr"}, bus.instr, ins);
    chk({tag, "_stall"}, bus.stall, !h);
    bus.fetch_en = 1'b0;
  endtask

  initial begin
    bus.pc = 16'h0000;
    bus.fetch_en = 1'b1;
    bus.flush = 1'b0;
    bus.mem_data_res = '0;
    repeat (2) tick();
    chk("rst_hit", bus.hit, 1'b0);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_req_valid", bus.mem_req.valid, 1'b0);
    chk("rst_req_rw", bus.mem_req.rw, 1'b0);
    chk("rst_miss_cnt", bus.miss_cnt, 16'd0);
    bus.fetch_en = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_stall", bus.stall, 1'b0);
    // cold miss with zero-wait memory
    do_miss(16'h0000, 64'h4444_3333_2222_1111, 0, 1'b0);
    probe("cold_w2", 16'h0002, 1'b1, 16'h3333);
    probe("cold_w3", 16'h0003, 1'b1, 16'h4444);
    chk("cold_cnt", bus.miss_cnt, 16'd1);
    chk("req_data", bus.mem_req.data, 64'h0);
    // conflict on index 0
    do_miss(16'h0100, 64'hDDDD_CCCC_BBBB_AAAA, 0, 1'b0);
    probe("conf_new", 16'h0100, 1'b1, 16'hAAAA);
    probe("conf_old", 16'h0000, 1'b0, 16'h0000);
    do_miss(16'h0000, 64'h4444_3333_2222_1111, 0, 1'b0);
    probe("refill", 16'h0001, 1'b1, 16'h2222);
    // delayed memory, then a stray ready in COMPARE
    do_miss(16'h0004, 64'h8888_7777_6666_5555, 4, 1'b0);
    probe("delay", 16'h0007, 1'b1, 16'h8888);
    bus.mem_data_res.data = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.mem_data_res.ready = 1'b1;
    tick();
    bus.mem_data_res.ready = 1'b0;
    chk("stray_valid", bus.mem_req.valid, 1'b0);
    chk("stray_stall", bus.stall, 1'b0);
    tick();
    probe("stray_line", 16'h0008, 1'b0, 16'h0000);
    probe("stray_keep", 16'h0006, 1'b1, 16'h7777);
    chk("delay_cnt", bus.miss_cnt, 16'd4);
    // pc moves while the fill is outstanding
    bus.pc = 16'h0040;
    bus.fetch_en = 1'b1;
    tick();
    bus.pc = 16'h0080;
    #1;
    chk("move_addr", bus.mem_req.addr, 14'h0010);
    bus.mem_data_res.data = 64'h0D0D_0C0C_0B0B_0A0A;
    bus.mem_data_res.ready = 1'b1;
    tick();
    bus.mem_data_res.ready = 1'b0;
    tick();
    #1;
    chk("move_new_hit", bus.hit, 1'b0);
    chk("move_new_stall", bus.stall, 1'b1);
    probe("move_old", 16'h0041, 1'b1, 16'h0B0B);
    // flush during FILL keeps the line invalid
    do_miss(16'h0200, 64'h1234_5678_9ABC_DEF0, 0, 1'b1);
    probe("flfill", 16'h0200, 1'b0, 16'h0000);
    do_miss(16'h0000, 64'h4444_3333_2222_1111, 1, 1'b0);
    do_miss(16'h0004, 64'h8888_7777_6666_5555, 0, 1'b0);
    probe("pre_fl0", 16'h0000, 1'b1, 16'h1111);
    probe("pre_fl1", 16'h0005, 1'b1, 16'h6666);
    chk("fl_cnt", bus.miss_cnt, 16'd8);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    probe("post_fl0", 16'h0000, 1'b0, 16'h0000);
    probe("post_fl1", 16'h0005, 1'b0, 16'h0000);
    probe("post_fl2", 16'h0041, 1'b0, 16'h0000);
    // reset abandons an outstanding fill
    bus.pc = 16'h0008;
    bus.fetch_en = 1'b1;
    tick();
    chk("rstm_valid_pre", bus.mem_req.valid, 1'b1);
    bus.fetch_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstm_valid", bus.mem_req.valid, 1'b0);
    chk("rstm_stall", bus.stall, 1'b0);
    bus.mem_data_res.data = 64'h5555_5555_5555_5555;
    bus.mem_data_res.ready = 1'b1;
    tick();
    bus.mem_data_res.ready = 1'b0;
    rst = 1'b0;
    tick();
    chk("rstm_cnt", bus.miss_cnt, 16'd0);
    probe("rstm_retry", 16'h0008, 1'b0, 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port pc, input, 16 bits: fetch word address; tag=pc[15:8], index=pc[7:2], offset=pc[1:0].
REQ-004 SHALL have port fetch_en, input, 1 bit: fetch request valid this cycle.
REQ-005 SHALL have port flush, input, 1 bit: invalidate all lines.
REQ-006 SHALL have port mem_data_res, input, mem_data_type: data[63:0] line from unified memory, ready.
REQ-007 SHALL have port instr, output, 16 bits: fetched instruction word.
REQ-008 SHALL have port hit, output, 1 bit: instr valid this cycle.
REQ-009 SHALL have port stall, output, 1 bit: fetch stage must hold pc.
REQ-010 SHALL have port mem_req, output, mem_req_type: addr[13:0] line address, data[63:0], rw (1=write), valid.
REQ-011 SHALL have port miss_cnt, output, 16 bits: saturating miss counter.

Function
REQ-012 SHALL be a direct-mapped cache: 64 lines, 4 x 16-bit words per line, one valid bit and 8-bit tag per line.
REQ-013 SHALL implement FSM states COMPARE, ALLOCATE, FILL.
REQ-014 In COMPARE, hit SHALL equal fetch_en & valid[index] & (tag_arr[index]==pc[15:8]), combinationally, same cycle (zero-cycle hit latency).
REQ-015 instr SHALL be word pc[1:0] of the indexed line when hit=1, else 16'h0000; word 0 occupies data[15:0], word 3 data[63:48].
REQ-016 COMPARE with fetch_en=1 and hit=0 SHALL latch pc[15:2] into miss_line, assert stall, increment miss_cnt, and move to ALLOCATE.
REQ-017 In ALLOCATE, mem_req.valid SHALL be 1, mem_req.addr SHALL be miss_line, mem_req.rw SHALL be 0, mem_req.data SHALL be 64'h0; held stable until mem_data_res.ready=1.
REQ-018 mem_data_res.ready SHALL be sampled only in ALLOCATE; ready seen in any other state SHALL be ignored.
REQ-019 ALLOCATE with ready=1 SHALL capture mem_data_res.data into a line buffer and move to FILL.
REQ-020 FILL SHALL write the buffered line, tag miss_line[13:6], and valid=1 at index miss_line[5:0], then return to COMPARE (one cycle).
REQ-021 stall SHALL be 1 in ALLOCATE and FILL, and in COMPARE exactly when fetch_en=1 and hit=0; else 0.
REQ-022 mem_req.valid SHALL be 0 outside ALLOCATE.
REQ-023 pc changes during ALLOCATE/FILL SHALL NOT alter miss_line; the fill completes for the latched line, and the new pc is compared on return to COMPARE.
REQ-024 flush SHALL clear all valid bits at the next edge in any state; the FSM state is unaffected.
REQ-025 flush asserted in FILL SHALL win: the line is written but valid stays 0.
REQ-026 fetch_en=0 in COMPARE SHALL give hit=0, stall=0, no state change.
REQ-027 miss_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-028 Unified-memory latency SHALL NOT be assumed; any number of ALLOCATE cycles is legal.

Reset
REQ-029 rst=1 SHALL asynchronously force state=COMPARE, all valid=0, miss_cnt=0, miss_line=0, line buffer=0.
REQ-030 During and immediately after reset, outputs SHALL be hit=0, instr=0, stall=0, mem_req.valid=0, mem_req.rw=0.
REQ-031 Reset mid-ALLOCATE or mid-FILL SHALL abandon the fill; no line becomes valid.
REQ-032 Tag and data arrays SHALL NOT require reset; contents are qualified by valid.

Structure
REQ-033 mem_req_type, mem_data_type, and the FSM state enum SHALL live in the shared icache_def package; line/tag/index widths SHALL be package localparams.
REQ-034 Data storage SHALL be sub-module icache_data_array (64 x 64-bit, one sync write port, async read port); the valid and tag arrays SHALL be in icache_ctrl.

Verification
REQ-035 Cold miss: after reset, pc=0x0000, fetch_en=1 SHALL give stall=1, mem_req.valid=1, addr=14'h0000; ready with data 64'h4444_3333_2222_1111 SHALL then give pc=0x0002 hit=1, instr=16'h3333, stall=0, miss_cnt=1.
REQ-036 Conflict: with line 0 filled, pc=0x0100 (same index, tag 0x01) SHALL miss; after refill, pc=0x0000 SHALL miss again.
REQ-037 Delayed memory: ready withheld 4 cycles SHALL keep mem_req addr/valid stable and stall=1 for the whole wait; ready pulsed in COMPARE SHALL be ignored.
REQ-038 pc changed from 0x0040 to 0x0080 mid-ALLOCATE SHALL fill line 0x0010, then 0x0080 SHALL miss.
REQ-039 flush in FILL SHALL leave the line invalid; flush in COMPARE after fills SHALL make all previously hitting pcs miss.
REQ-040 rst asserted mid-ALLOCATE SHALL immediately drop mem_req.valid and stall; a retry of the same pc SHALL miss.
